// File: rtl/fll_cfg_bridge.sv
// APB slave that turns each register access into one FLL CFGREQ/CFGACK transaction, with timeout.
// Define FLL_CFG_ACK_SYNC_EN to pass cfg_ack_i through a two-flop synchroniser (FLL on another clock).
module fll_cfg_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned CFG_ADDR_WIDTH = 4,
    parameter int unsigned CFG_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [CFG_DATA_WIDTH-1:0] pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [CFG_DATA_WIDTH-1:0] prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      cfg_req_o,
    input  logic                      cfg_ack_i,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_ad_o,
    output logic [CFG_DATA_WIDTH-1:0] cfg_d_o,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_q_i,
    output logic                      cfg_web_o
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                    state_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic                      cfg_req_q;
    logic [CFG_ADDR_WIDTH-1:0] cfg_ad_q;
    logic [CFG_DATA_WIDTH-1:0] cfg_d_q;
    logic                      cfg_web_q;
    logic [CFG_DATA_WIDTH-1:0] prdata_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic                      ack_s;

    // Only the word-index bits below the config address reach the FLL.
    logic unused_paddr_c;
    assign unused_paddr_c = ^paddr_i[APB_ADDR_WIDTH-1:CFG_ADDR_WIDTH+2];

`ifdef FLL_CFG_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= 2'b00;
        end else begin
            ack_sync_q <= {ack_sync_q[0], cfg_ack_i};
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = cfg_ack_i;
`endif

    // Transfer FSM; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cfg_req_q <= 1'b0;
            cfg_ad_q  <= '0;
            cfg_d_q   <= '0;
            cfg_web_q <= 1'b1;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && penable_i) begin
                        if (paddr_i[1:0] == 2'b00) begin
                            cfg_ad_q  <= paddr_i[CFG_ADDR_WIDTH+1:2];
                            cfg_d_q   <= pwdata_i;
                            cfg_web_q <= ~pwrite_i;
                            cfg_req_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= REQ;
                        end else begin
                            prdata_q  <= '0;
                            pslverr_q <= 1'b1;
                            pready_q  <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked before the timeout so a coincident ack still succeeds.
                    if (ack_s) begin
                        cfg_req_q <= 1'b0;
                        prdata_q  <= cfg_web_q ? cfg_q_i : '0;
                        pslverr_q <= 1'b0;
                        pready_q  <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
                        cfg_req_q <= 1'b0;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign cfg_req_o = cfg_req_q;
    assign cfg_ad_o  = cfg_ad_q;
    assign cfg_d_o   = cfg_d_q;
    assign cfg_web_o = cfg_web_q;

endmodule

// File: tb/tb_fll_cfg_bridge.sv
// Directed bench for fll_cfg_bridge: latency, data, timeout, unaligned, ack/timeout race and async reset.
`timescale 1ns/1ps
module tb_fll_cfg_bridge;

    localparam int unsigned AW = 12;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef FLL_CFG_ACK_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic          pwrite = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          cfg_req;
    logic          cfg_ack;
    logic [CW-1:0] cfg_ad;
    logic [DW-1:0] cfg_d;
    logic [DW-1:0] cfg_q = '0;
    logic          cfg_web;

    logic ack_follow = 1'b1;
    logic ack_drv = 1'b0;
    assign cfg_ack = ack_follow ? cfg_req : ack_drv;

    int total = 0;
    int bad = 0;

    int            lat;
    int            nreq;
    logic [DW-1:0] rdata;
    logic          err;

    fll_cfg_bridge #(
        .APB_ADDR_WIDTH(AW),
        .CFG_ADDR_WIDTH(CW),
        .CFG_DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .paddr_i(paddr),
        .pwdata_i(pwdata),
        .pwrite_i(pwrite),
        .psel_i(psel),
        .penable_i(penable),
        .prdata_o(prdata),
        .pready_o(pready),
        .pslverr_o(pslverr),
        .cfg_req_o(cfg_req),
        .cfg_ack_i(cfg_ack),
        .cfg_ad_o(cfg_ad),
        .cfg_d_o(cfg_d),
        .cfg_q_i(cfg_q),
        .cfg_web_o(cfg_web)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Setup phase then access phase; returns mid-cycle A.
    task automatic apb_start(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        chk("req_low_in_A", 32'(cfg_req), 32'd0);
    endtask

    // Waits for pready (bounded), optional one-cycle ack pulse at cycle A+pulse_k.
    task automatic apb_finish(input int pulse_k, output int lat_o, output int nreq_o,
                              output logic [DW-1:0] rdata_o, output logic err_o);
        logic done;
        done = 1'b0; lat_o = 0; nreq_o = 0; rdata_o = '0; err_o = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            ack_drv = (pulse_k > 0 && k == pulse_k);
            if (cfg_req) nreq_o++;
            if (pready) begin
                lat_o = k; rdata_o = prdata; err_o = pslverr; done = 1'b1;
                psel = 1'b0; penable = 1'b0;
            end
        end
        chk("pready_seen", 32'(done), 32'd1);
        @(negedge clk);
        ack_drv = 1'b0;
        chk("pready_drop", 32'(pready), 32'd0);
        chk("pslverr_drop", 32'(pslverr), 32'd0);
        chk("req_after", 32'(cfg_req), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_req", 32'(cfg_req), 32'd0);
        chk("rst_ad", 32'(cfg_ad), 32'd0);
        chk("rst_d", cfg_d, 32'd0);
        chk("rst_web", 32'(cfg_web), 32'd1);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        rst_n = 1'b1;

        // Minimum-latency write
        ack_follow = 1'b1;
        apb_start(12'h008, 1'b1, 32'hCAFE0001);
        apb_finish(0, lat, nreq, rdata, err);
        chk("wr_lat", 32'(lat), 32'(2 + SL));
        chk("wr_nreq", 32'(nreq), 32'(1 + SL));
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_prdata", rdata, 32'd0);
        chk("wr_ad", 32'(cfg_ad), 32'd2);
        chk("wr_d", cfg_d, 32'hCAFE0001);
        chk("wr_web", 32'(cfg_web), 32'd0);

        // Minimum-latency read
        cfg_q = 32'hDEADBEEF;
        apb_start(12'h004, 1'b0, 32'h0);
        apb_finish(0, lat, nreq, rdata, err);
        chk("rd_lat", 32'(lat), 32'(2 + SL));
        chk("rd_prdata", rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(err), 32'd0);
        chk("rd_ad", 32'(cfg_ad), 32'd1);
        chk("rd_web", 32'(cfg_web), 32'd1);
        chk("rd_d", cfg_d, 32'd0);

        // Wait states: ack pulse at A+4
        ack_follow = 1'b0;
        apb_start(12'h020, 1'b1, 32'h00C0FFEE);
        apb_finish(4, lat, nreq, rdata, err);
        chk("ws_lat", 32'(lat), 32'(5 + SL));
        chk("ws_err", 32'(err), 32'd0);
        chk("ws_ad", 32'(cfg_ad), 32'd8);

        // Timeout read with ack held low
        cfg_q = 32'h12345678;
        apb_start(12'h00C, 1'b0, 32'h0);
        apb_finish(0, lat, nreq, rdata, err);
        chk("to_lat", 32'(lat), 32'(TO + 2));
        chk("to_nreq", 32'(nreq), 32'(TO + 1));
        chk("to_err", 32'(err), 32'd1);
        chk("to_prdata", rdata, 32'd0);
        chk("to_ad", 32'(cfg_ad), 32'd3);

        // Unaligned write: error without touching the FLL side
        apb_start(12'h006, 1'b1, 32'h55555555);
        apb_finish(0, lat, nreq, rdata, err);
        chk("ua_lat", 32'(lat), 32'd1);
        chk("ua_nreq", 32'(nreq), 32'd0);
        chk("ua_err", 32'(err), 32'd1);
        chk("ua_prdata", rdata, 32'd0);
        chk("ua_ad_hold", 32'(cfg_ad), 32'd3);
        chk("ua_web_hold", 32'(cfg_web), 32'd1);
        chk("ua_d_hold", cfg_d, 32'd0);

        // Ack arriving in the cycle the counter reaches TIMEOUT
        cfg_q = 32'hA5A55A5A;
        apb_start(12'h03C, 1'b0, 32'h0);
        apb_finish(TO + 1 - SL, lat, nreq, rdata, err);
        chk("race_lat", 32'(lat), 32'(TO + 2));
        chk("race_err", 32'(err), 32'd0);
        chk("race_prdata", rdata, 32'hA5A55A5A);
        chk("race_ad", 32'(cfg_ad), 32'd15);

        // Asynchronous reset while in REQ
        apb_start(12'h010, 1'b1, 32'h11112222);
        @(negedge clk);
        @(negedge clk);
        chk("rr_pre_req", 32'(cfg_req), 32'd1);
        chk("rr_pre_web", 32'(cfg_web), 32'd0);
        chk("rr_pre_ad", 32'(cfg_ad), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_req", 32'(cfg_req), 32'd0);
        chk("rr_web", 32'(cfg_web), 32'd1);
        chk("rr_ad", 32'(cfg_ad), 32'd0);
        chk("rr_d", cfg_d, 32'd0);
        chk("rr_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal read after reset release
        ack_follow = 1'b1;
        cfg_q = 32'h0BADF00D;
        apb_start(12'h008, 1'b0, 32'h0);
        apb_finish(0, lat, nreq, rdata, err);
        chk("pr_lat", 32'(lat), 32'(2 + SL));
        chk("pr_prdata", rdata, 32'h0BADF00D);
        chk("pr_err", 32'(err), 32'd0);
        chk("pr_ad", 32'(cfg_ad), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fll_cfg_bridge.md
# fll_cfg_bridge

APB slave that translates host register accesses into the FLL configuration handshake (CFGREQ/CFGACK, CFGAD, CFGD, CFGWEB, CFGQ). It sits directly upstream of the FLL macro, or its simulation stand-in, in the host clock subsystem. Each APB access becomes exactly one FLL config transaction. A timeout keeps the bus from hanging when the FLL never acknowledges.

## Interface
- APB_ADDR_WIDTH, 12: APB address width.
- CFG_ADDR_WIDTH, 4: FLL config address width.
- CFG_DATA_WIDTH, 32: APB and FLL config data width.
- TIMEOUT, 255: maximum cycles spent in REQ before an error response; must be ≥1.
- clk_i  in  1  host clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- paddr_i  in  APB_ADDR_WIDTH  APB address.
- pwdata_i  in  CFG_DATA_WIDTH  APB write data.
- pwrite_i  in  1  APB write (1) or read (0).
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- prdata_o  out  CFG_DATA_WIDTH  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- cfg_req_o  out  1  FLL CFGREQ.
- cfg_ack_i  in  1  FLL CFGACK.
- cfg_ad_o  out  CFG_ADDR_WIDTH  FLL CFGAD.
- cfg_d_o  out  CFG_DATA_WIDTH  FLL CFGD.
- cfg_q_i  in  CFG_DATA_WIDTH  FLL CFGQ.
- cfg_web_o  out  1  FLL CFGWEB (0 = write).

## Operation
- The FSM has three states: IDLE, REQ and RESP. All outputs are registered.
- IDLE:
  - A transfer is accepted when psel_i & penable_i.
  - Aligned access (paddr_i[1:0]==0):
    - Latch cfg_ad_o = paddr_i[CFG_ADDR_WIDTH+1:2].
    - Latch cfg_d_o = pwdata_i and cfg_web_o = ~pwrite_i.
    - Set cfg_req_o=1 and go to REQ.
  - Unaligned access: go to RESP with error set. The FLL is not accessed.
- REQ:
  - cfg_req_o stays high and the timeout counter increments every cycle.
  - Completion is defined as ack_s=1 at a clock edge. ack_s is cfg_ack_i, or its synchronised copy (see Configuration).
  - On completion:
    - Clear cfg_req_o.
    - On a read, capture cfg_q_i into prdata_o; on a write, prdata_o=0.
    - pslverr_o=0; go to RESP.
  - On timeout (counter==TIMEOUT with no ack):
    - Clear cfg_req_o.
    - Set prdata_o=0 and pslverr_o=1; go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - pready_o=1 for exactly one cycle, with prdata_o and pslverr_o valid.
  - In the next cycle: pready_o=0, pslverr_o=0, and the FSM returns to IDLE.
- cfg_ad_o, cfg_d_o and cfg_web_o hold their values until the next accepted transfer.
- The counter is $clog2(TIMEOUT+1) bits wide, cleared on REQ entry and saturating at TIMEOUT.
- APB violation (psel_i dropped mid-transfer): the FLL transaction still completes and the pready_o pulse is emitted regardless.
- Reset asserted mid-transaction: every output returns to its reset value immediately and asynchronously, and the FSM goes to IDLE.

## Timing
- Reset values: cfg_req_o=0, cfg_ad_o=0, cfg_d_o=0, cfg_web_o=1, prdata_o=0, pready_o=0, pslverr_o=0. The FSM resets to IDLE and the counter to 0.
- Let A be the first access-phase cycle. cfg_req_o rises at A+1.
- If ack_s is high at A+1, pready_o is high at A+2. This is the minimum: 3 access-phase cycles, zero wait on the FLL side.
- Each extra cycle of ack_s low adds one wait cycle.
- Timeout response: pready_o at A+TIMEOUT+2, with pslverr_o=1.
- Unaligned access: pready_o at A+1, pslverr_o=1, cfg_req_o never asserted.
- Back-to-back transfers: a new transfer is accepted at the earliest in the cycle after RESP.

## Configuration
- FLL_CFG_ACK_SYNC_EN:
  - Defined: cfg_ack_i passes through a two-flop synchroniser, reset to 0, before it is used as ack_s. Every ack-dependent latency grows by 2 cycles, so the minimum becomes pready_o at A+4.
  - Undefined: ack_s = cfg_ack_i combinationally, for an FLL clocked from the same domain.

## Test plan
- Write 0xCAFE0001 to paddr 0x008 with cfg_ack_i tied 1 -> cfg_ad_o=2, cfg_d_o=0xCAFE0001, cfg_web_o=0, cfg_req_o high for exactly 1 cycle, pready_o at A+2 (A+4 with FLL_CFG_ACK_SYNC_EN), pslverr_o=0.
- Read paddr 0x004 with cfg_q_i=0xDEADBEEF and ack tied 1 -> cfg_web_o=1, cfg_ad_o=1, prdata_o=0xDEADBEEF in the pready_o cycle.
- Read with cfg_ack_i held 0 and TIMEOUT=8 -> cfg_req_o high for 9 cycles then low, pready_o at A+10 with pslverr_o=1 and prdata_o=0.
- Write to unaligned paddr 0x006 -> pready_o at A+1, pslverr_o=1, cfg_req_o never rises.
- Ack pulse arriving on the same cycle as timeout expiry -> success response with pslverr_o=0.
- Assert rst_ni low while in REQ -> cfg_req_o=0 and cfg_web_o=1 without waiting for a clock edge. After reset release, a new read completes normally.
